// File: rtl/dm_responder.sv
// Data-memory responder for the MEM stage: word array with bit-masked writes
// and reads that complete LATENCY+1 cycles after acceptance.
module dm_responder #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  chip_select,
    input  logic                  SRAM_web,
    input  logic [DATA_WIDTH-1:0] w_eb,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] DM_in,
    output logic [DATA_WIDTH-1:0] DM_out,
    output logic                  rd_valid,
    output logic                  busy
);

    localparam int CNT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t                state, state_nx;
    logic [CNT_W-1:0]      cnt, cnt_nx;
    logic [DATA_WIDTH-1:0] resp, resp_nx;
    logic [DATA_WIDTH-1:0] dout_nx;
    logic                  rd_valid_nx;
    logic                  accept, rd_accept, wr_accept;

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    assign busy      = (state == WAIT);
    assign accept    = !chip_select && (state == IDLE);
    assign rd_accept = accept && SRAM_web;
    assign wr_accept = accept && !SRAM_web;

    // Array has no reset so its contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_accept)
            mem[addr] <= (mem[addr] & w_eb) | (DM_in & ~w_eb);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            resp     <= '0;
            DM_out   <= '0;
            rd_valid <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            resp     <= resp_nx;
            DM_out   <= dout_nx;
            rd_valid <= rd_valid_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        resp_nx     = resp;
        dout_nx     = DM_out;
        rd_valid_nx = 1'b0;
        case (state)
            IDLE: begin
                if (rd_accept) begin
                    if (LATENCY == 0) begin
                        dout_nx     = mem[addr];
                        rd_valid_nx = 1'b1;
                    end else begin
                        // Snapshot now so in-flight data is immune to later writes.
                        resp_nx  = mem[addr];
                        cnt_nx   = CNT_W'(LATENCY);
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    state_nx    = IDLE;
                    cnt_nx      = '0;
                    dout_nx     = resp;
                    rd_valid_nx = 1'b1;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: three instances (LATENCY 0, 3, 2) on a shared request
// bus, expected reads queued per instance and checked when rd_valid fires.
module tb_dm_responder;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    typedef struct {
        logic        web;
        logic [31:0] mask;
        logic [13:0] addr;
        logic [31:0] din;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cs0 = 1'b1, cs3 = 1'b1, cs2 = 1'b1;
    logic        web = 1'b1;
    logic [31:0] mask = '1;
    logic [13:0] addr = '0;
    logic [31:0] din = '0;
    logic [31:0] dout0, dout3, dout2;
    logic        rv0, rv3, rv2, bsy0, bsy3, bsy2;

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t q[3][$];
    vec_t tbl[10];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dm_responder #(.ADDR_WIDTH(14), .DATA_WIDTH(32), .LATENCY(0)) u_l0 (
        .clk(clk), .rst(rst), .chip_select(cs0), .SRAM_web(web), .w_eb(mask),
        .addr(addr), .DM_in(din), .DM_out(dout0), .rd_valid(rv0), .busy(bsy0));
    dm_responder #(.ADDR_WIDTH(14), .DATA_WIDTH(32), .LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst), .chip_select(cs3), .SRAM_web(web), .w_eb(mask),
        .addr(addr), .DM_in(din), .DM_out(dout3), .rd_valid(rv3), .busy(bsy3));
    dm_responder #(.ADDR_WIDTH(14), .DATA_WIDTH(32), .LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst), .chip_select(cs2), .SRAM_web(web), .w_eb(mask),
        .addr(addr), .DM_in(din), .DM_out(dout2), .rd_valid(rv2), .busy(bsy2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic mon(input int i, input logic v, input logic [31:0] d);
        exp_t e;
        if (v) begin
            if (q[i].size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_rd_valid[%0d]: got rd_valid=1 expected no read pending (cycle %0d)", i, cyc);
            end else begin
                e = q[i].pop_front();
                chk($sformatf("rd_data[%0d]", i), d, e.data);
                chk($sformatf("rd_cycle[%0d]", i), 32'(cyc), 32'(e.due));
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, rv0, dout0);
        mon(1, rv3, dout3);
        mon(2, rv2, dout2);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int i, input logic [31:0] d, input int lat);
        exp_t e;
        e.data = d;
        e.due  = cyc + 1 + lat;
        q[i].push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{1'b0, 32'h00000000, 14'd5, 32'hDEADBEEF, 32'h0};
        tbl[1] = '{1'b1, 32'h00000000, 14'd5, 32'h0,        32'hDEADBEEF};
        tbl[2] = '{1'b0, 32'h00000000, 14'd7, 32'h11223344, 32'h0};
        tbl[3] = '{1'b0, 32'hFF00FFFF, 14'd7, 32'h00AB0000, 32'h0};
        tbl[4] = '{1'b1, 32'hFFFFFFFF, 14'd7, 32'h0,        32'h11AB3344};
        tbl[5] = '{1'b0, 32'h00000000, 14'd2, 32'hAAAAAAAA, 32'h0};
        tbl[6] = '{1'b0, 32'h0000FFFF, 14'd2, 32'h12340000, 32'h0};
        tbl[7] = '{1'b0, 32'hFFFFFFFF, 14'd2, 32'h00000000, 32'h0};
        tbl[8] = '{1'b1, 32'h00000000, 14'd2, 32'h0,        32'h1234AAAA};
        tbl[9] = '{1'b1, 32'h00000000, 14'd5, 32'h0,        32'hDEADBEEF};

        // Reset state
        #12;
        chk("rst_busy", {31'b0, bsy0}, 32'h0);
        chk("rst_rd_valid", {31'b0, rv0}, 32'h0);
        chk("rst_dout", dout0, 32'h0);
        chk("rst_busy_l3", {31'b0, bsy3}, 32'h0);
        step();
        rst = 1'b1;

        // LATENCY=0 table: writes, masked writes, read-after-write, back-to-back reads
        for (int i = 0; i < 10; i++) begin
            step();
            cs0  = 1'b0;
            web  = tbl[i].web;
            mask = tbl[i].mask;
            addr = tbl[i].addr;
            din  = tbl[i].din;
            if (tbl[i].web) push(0, tbl[i].exp, 0);
            chk("l0_busy", {31'b0, bsy0}, 32'h0);
        end
        step();
        cs0 = 1'b1;
        repeat (3) step();
        chk("l0_hold_dout", dout0, 32'hDEADBEEF);
        chk("l0_queue_drained", 32'(q[0].size()), 32'h0);

        // LATENCY=3: busy window, ignored request while busy, accept on rd_valid cycle
        step(); cs3 = 1'b0; web = 1'b0; mask = '0; addr = 14'd4; din = 32'hCAFE0004;
        step(); addr = 14'd6; din = 32'h00000066;
        step(); web = 1'b1; addr = 14'd4; push(1, 32'hCAFE0004, 3);
        step(); cs3 = 1'b1;
        chk("l3_busy_c1", {31'b0, bsy3}, 32'h1);
        step(); cs3 = 1'b0; addr = 14'd6;
        chk("l3_busy_c2", {31'b0, bsy3}, 32'h1);
        step(); cs3 = 1'b1;
        chk("l3_busy_c3", {31'b0, bsy3}, 32'h1);
        step(); cs3 = 1'b0; addr = 14'd6; push(1, 32'h00000066, 3);
        chk("l3_busy_c4", {31'b0, bsy3}, 32'h0);
        chk("l3_rd_valid_c4", {31'b0, rv3}, 32'h1);
        step(); cs3 = 1'b1;
        repeat (5) step();
        chk("l3_queue_drained", 32'(q[1].size()), 32'h0);

        // LATENCY=2: write during in-flight read is ignored
        step(); cs2 = 1'b0; web = 1'b0; mask = '0; addr = 14'd9; din = 32'h5;
        step(); web = 1'b1; push(2, 32'h5, 2);
        step(); web = 1'b0; din = 32'h6;
        chk("l2_busy", {31'b0, bsy2}, 32'h1);
        step(); cs2 = 1'b1;
        repeat (3) step();
        chk("l2_dout_after", dout2, 32'h5);
        cs2 = 1'b0; web = 1'b1; addr = 14'd9; push(2, 32'h5, 2);
        step(); cs2 = 1'b1;
        repeat (4) step();
        chk("l2_queue_drained", 32'(q[2].size()), 32'h0);

        // Reset mid-WAIT on LATENCY=3 drops the pending read
        step(); cs3 = 1'b0; web = 1'b1; addr = 14'd4;
        step(); cs3 = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("midrst_busy", {31'b0, bsy3}, 32'h0);
        chk("midrst_rd_valid", {31'b0, rv3}, 32'h0);
        chk("midrst_dout", dout3, 32'h0);
        step(); step();
        rst = 1'b1;

        // Array contents survive reset
        step(); cs0 = 1'b0; web = 1'b1; addr = 14'd5; push(0, 32'hDEADBEEF, 0);
        step(); cs0 = 1'b1;
        repeat (6) step();
        chk("final_q0", 32'(q[0].size()), 32'h0);
        chk("final_q1", 32'(q[1].size()), 32'h0);
        chk("final_q2", 32'(q[2].size()), 32'h0);
        chk("final_busy_l3", {31'b0, bsy3}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
Data-memory responder for the MEM stage. It sits at the far end of the DM interface and serves the MEM stage's chip select, read/write strobe, bit-level write mask and store data, returning load data. It holds a synchronous word-organised array with bit-masked writes. Reads take LATENCY+1 cycles; a busy flag lets the pipeline stall on slow memory.

Parameters:
ADDR_WIDTH, 14, word-address width; array depth = 2**ADDR_WIDTH words
DATA_WIDTH, 32, word width (equals `DATA_WIDTH)
LATENCY, 0, extra wait cycles per read (0..15)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous reset, active-low
chip_select  input  1  active-low request strobe
SRAM_web  input  1  1 = read, 0 = write
w_eb  input  DATA_WIDTH  active-low bit write enable; bit i = 0 writes bit i
addr  input  ADDR_WIDTH  word address (byte address [ADDR_WIDTH+1:2])
DM_in  input  DATA_WIDTH  store data, already lane-aligned by the requester
DM_out  output  DATA_WIDTH  read data
rd_valid  output  1  one-cycle pulse when DM_out is updated with a new read
busy  output  1  high while a read is outstanding; requests are ignored

Behaviour:
- Reset (rst = 0, asynchronous): FSM to IDLE, wait counter = 0, busy = 0, rd_valid = 0, DM_out = 0. Array contents are not cleared and are retained across reset.
- Acceptance: a request is accepted at a rising edge when chip_select = 0 and busy = 0. A request presented while busy = 1 has no effect and is not queued. The requester must re-present it.
- Write (SRAM_web = 0), committed at the accept edge: for every bit i, mem[addr][i] = w_eb[i] ? mem[addr][i] : DM_in[i].
  - w_eb all ones: no-op.
  - Writes never raise busy and never pulse rd_valid.
- Read (SRAM_web = 1):
  - mem[addr] is sampled at the accept edge into a response register. Later writes do not alter an in-flight response.
  - w_eb and DM_in are ignored.
- FSM states: IDLE and WAIT.
  - IDLE, read accepted, LATENCY = 0: DM_out and rd_valid = 1 in cycle E+1; stay IDLE.
  - IDLE, read accepted, LATENCY > 0: go to WAIT, load counter = LATENCY, busy = 1 from cycle E+1.
  - WAIT: decrement each cycle. On the edge where the counter reaches 1, return to IDLE, drive DM_out, pulse rd_valid and drop busy.
  - Net timing: busy high for cycles E+1..E+LATENCY; DM_out and rd_valid valid in cycle E+LATENCY+1.
  - A new request may be accepted in the same cycle that rd_valid is high (back-to-back reads at LATENCY+1 spacing).
- DM_out holds the last read value until the next read completes. rd_valid is high for exactly one cycle per read.
- Read-after-write: a write at edge E followed by a read of the same address at E+1 returns the written data.
- Reset mid-operation: a pending read is dropped, no rd_valid is produced, and busy clears immediately.
- Counter width is clog2(LATENCY+1), minimum 1 bit. All address values are in range (no wrap logic).

Test Plan:
- Reset: assert rst = 0 mid-WAIT with LATENCY = 3 -> busy = 0, rd_valid = 0 and DM_out = 0 immediately. No rd_valid follows after release.
- Full-word write/read, LATENCY = 0: write addr 5 = 32'hDEADBEEF (w_eb = 0), read addr 5 next cycle -> DM_out = 32'hDEADBEEF with rd_valid in the cycle after the read accept.
- Byte-masked write: preload addr 7 = 32'h11223344, write DM_in = 32'h00AB0000 with w_eb = 32'hFF00FFFF -> read returns 32'h11AB3344.
- Halfword plus no-op write: preload addr 2 = 32'hAAAAAAAA, then:
  - w_eb = 32'h0000FFFF, DM_in = 32'h12340000;
  - then w_eb = 32'hFFFFFFFF, DM_in = 32'h0;
  - expected read -> 32'h1234AAAA.
- Latency, LATENCY = 3: read accepted at cycle 0 -> busy high in cycles 1-3, rd_valid and DM_out in cycle 4. A second read presented in cycle 2 is ignored (no extra rd_valid). A read presented in cycle 4 is accepted, with rd_valid in cycle 8.
- In-flight isolation, LATENCY = 2: read addr 9 (= 32'h5), then write addr 9 = 32'h6 while busy -> write ignored; DM_out = 32'h5, and a subsequent read returns 32'h5.
